// File: rtl/taximeter_scan_if.sv
// Display-scan bus: fare/distance BCD in, one multiplexed digit out.
interface taximeter_scan_if;
    logic        scan_en;
    logic [15:0] fare_bcd;
    logic [15:0] dist_bcd;
    logic [3:0]  digit_bcd;
    logic [7:0]  dig_sel;
    logic        dp;
    logic        blank;

    // Meter-side producer of the readings.
    modport master (
        output scan_en, fare_bcd, dist_bcd,
        input  digit_bcd, dig_sel, dp, blank
    );

    // Scanner consuming readings and driving the display.
    modport slave (
        input  scan_en, fare_bcd, dist_bcd,
        output digit_bcd, dig_sel, dp, blank
    );
endinterface

// File: rtl/taximeter_scan.sv
// Eight-digit multiplexed display scanner for a taximeter.
// Positions 0..3 show the fare (ddd.d yuan), positions 4..7 the
// distance (ddd.d km). Inputs are latched once per frame, at the 7->0
// wrap, so a reading never tears within a frame. Outputs are a thin
// decode of registered state and are gated by scan_en, so pausing
// darkens the display in the same cycle and the digit interrupted by a
// pause keeps all of its remaining lit cycles on resume.
module taximeter_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    taximeter_scan_if.slave bus
);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TC_VAL = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [15:0]   r_fare_sh;
    logic [15:0]   r_dist_sh;

    logic          w_tc;
    logic          w_wrap;
    logic [15:0]   w_grp;
    logic [3:0]    w_raw;
    logic          w_zero_blank;
    logic [3:0]    w_digit;
    logic [7:0]    w_sel;
    logic          w_dp;
    logic          w_blank;

    assign w_tc   = bus.scan_en && (r_presc == TC_VAL);
    assign w_wrap = w_tc && (r_idx == 3'd7);

    // Prescaler: counts lit cycles of the current digit, frozen while paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
        end else if (bus.scan_en) begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Digit index: advances on terminal count, wraps 7->0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 3'd0;
        end else if (w_tc) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // Shadow readings: captured only at the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fare_sh <= 16'h0000;
            r_dist_sh <= 16'h0000;
        end else if (w_wrap) begin
            r_fare_sh <= bus.fare_bcd;
            r_dist_sh <= bus.dist_bcd;
        end
    end

    // Select the active digit and decide leading-zero suppression.
    always_comb begin
        w_grp        = r_idx[2] ? r_dist_sh : r_fare_sh;
        w_raw        = 4'd0;
        w_zero_blank = 1'b0;
        case (r_idx[1:0])
            2'd0: w_raw = w_grp[3:0];
            2'd1: w_raw = w_grp[7:4];
            2'd2: begin
                w_raw        = w_grp[11:8];
                w_zero_blank = (w_grp[15:12] == 4'd0) && (w_grp[11:8] == 4'd0);
            end
            default: begin
                w_raw        = w_grp[15:12];
                w_zero_blank = (w_grp[15:12] == 4'd0);
            end
        endcase
    end

    // Drive the display: reset look, dark while paused, else the active digit.
    always_comb begin
        w_digit = 4'd0;
        w_sel   = 8'hFF;
        w_dp    = 1'b0;
        w_blank = 1'b1;
        if (!rst_n) begin
            w_sel   = 8'hFE;
            w_blank = 1'b0;
        end else if (bus.scan_en) begin
            w_sel   = ~(8'd1 << r_idx);
            w_dp    = (r_idx[1:0] == 2'd1);
            w_blank = w_zero_blank;
            w_digit = w_zero_blank ? 4'd0 : w_raw;
        end
    end

    assign bus.digit_bcd = w_digit;
    assign bus.dig_sel   = w_sel;
    assign bus.dp        = w_dp;
    assign bus.blank     = w_blank;

endmodule

// File: tb/tb_taximeter_scan.sv
// Directed bench for taximeter_scan: SCAN_DIV=4 main instance plus a
// SCAN_DIV=1 instance for the every-cycle scan case.
module tb_taximeter_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    taximeter_scan_if if4();
    taximeter_scan_if if1();

    taximeter_scan #(.SCAN_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    taximeter_scan #(.SCAN_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int n_vec = 0;
    int n_err = 0;

    localparam logic [7:0] SEL   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    localparam logic       DP_T  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic       F1_BL [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [3:0] F2_D  [8] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd6, 4'd5, 4'd0, 4'd0};
    localparam logic       F2_BL [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [3:0] D1_D  [8] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd10, 4'd0, 4'd0};

    // Expected {digit_bcd, dig_sel, dp, blank} for a lit position.
    function automatic logic [13:0] mk(input logic [3:0] d, input int p,
                                       input logic pdp, input logic pbl);
        return {d, SEL[p], pdp, pbl};
    endfunction

    function automatic logic [13:0] obs4();
        return {if4.digit_bcd, if4.dig_sel, if4.dp, if4.blank};
    endfunction

    function automatic logic [13:0] obs1();
        return {if1.digit_bcd, if1.dig_sel, if1.dp, if1.blank};
    endfunction

    task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed={bcd,sel,dp,blank}=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [13:0] o;

    initial begin
        if4.scan_en  = 1'b1;
        if4.fare_bcd = 16'h1234;
        if4.dist_bcd = 16'h0056;
        if1.scan_en  = 1'b1;
        if1.fare_bcd = 16'h1234;
        if1.dist_bcd = 16'h00A0;

        #2;
        chk("reset_outputs", obs4(), mk(4'd0, 0, 1'b0, 1'b0));
        #10;
        rst_n = 1'b1;

        // Frame 1: shadows still zero, leading zeros suppressed.
        adv(1);
        for (int p = 0; p < 8; p++) begin
            chk($sformatf("frame1_pos%0d", p), obs4(), mk(4'd0, p, DP_T[p], F1_BL[p]));
            adv(4);
        end

        // Frame 2: 1234 / 0056 captured, every cycle checked.
        for (int c = 0; c < 32; c++) begin
            int i;
            i = ((c + 1) / 4) % 8;
            chk($sformatf("frame2_cyc%0d", c), obs4(), mk(F2_D[i], i, DP_T[i], F2_BL[i]));
            adv(1);
        end

        // Fare changes mid-frame at index 2: no tearing.
        adv(8);
        if4.fare_bcd = 16'h9999;
        adv(1);
        chk("tear_pos2", obs4(), mk(4'd2, 2, 1'b0, 1'b0));
        adv(4);
        chk("tear_pos3", obs4(), mk(4'd1, 3, 1'b0, 1'b0));

        // Pause at index 3, prescaler 2.
        if4.scan_en = 1'b0;
        #1;
        o = obs4();
        chk("pause_now", {4'h0, o[9:0]}, {4'h0, 8'hFF, 1'b0, 1'b1});
        adv(10);
        o = obs4();
        chk("pause_hold", {4'h0, o[9:0]}, {4'h0, 8'hFF, 1'b0, 1'b1});
        if4.scan_en = 1'b1;
        #1;
        chk("resume_presc2", obs4(), mk(4'd1, 3, 1'b0, 1'b0));
        adv(1);
        chk("resume_presc3", obs4(), mk(4'd1, 3, 1'b0, 1'b0));
        adv(1);
        chk("resume_next", obs4(), mk(4'd6, 4, 1'b0, 1'b0));

        // 9s appear after the wrap.
        adv(16);
        chk("new_pos0", obs4(), mk(4'd9, 0, 1'b0, 1'b0));
        adv(4);
        chk("new_pos1", obs4(), mk(4'd9, 1, 1'b1, 1'b0));
        adv(8);
        chk("new_pos3", obs4(), mk(4'd9, 3, 1'b0, 1'b0));

        // Zero fare.
        if4.fare_bcd = 16'h0000;
        adv(20);
        chk("zero_pos0", obs4(), mk(4'd0, 0, 1'b0, 1'b0));
        adv(4);
        chk("zero_pos1", obs4(), mk(4'd0, 1, 1'b1, 1'b0));
        adv(4);
        chk("zero_pos2", obs4(), mk(4'd0, 2, 1'b0, 1'b1));
        adv(4);
        chk("zero_pos3", obs4(), mk(4'd0, 3, 1'b0, 1'b1));

        // Asynchronous reset at index 6.
        adv(12);
        chk("pre_rst_pos6", obs4(), mk(4'd0, 6, 1'b0, 1'b1));
        if4.fare_bcd = 16'h1234;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", obs4(), mk(4'd0, 0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        adv(1);
        chk("post_rst_pos0", obs4(), mk(4'd0, 0, 1'b0, 1'b0));
        adv(31);
        chk("first_capture", obs4(), mk(4'd4, 0, 1'b0, 1'b0));

        // SCAN_DIV=1 instance: one position per cycle, 10 forwarded at position 5.
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("div1_pos%0d", c), obs1(), mk(D1_D[c], c, DP_T[c], F2_BL[c]));
            adv(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/taximeter_scan.md
TAXIMETER_SCAN -- requirements
Module: taximeter_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit stays lit (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port scan_en  input  1  scanning enable.
REQ-005 SHALL have port fare_bcd  input  16  fare in 0.1-yuan units, four BCD digits, [3:0]=d0 (LSD).
REQ-006 SHALL have port dist_bcd  input  16  distance in 0.1-km units, four BCD digits, [3:0]=d0.
REQ-007 SHALL have port digit_bcd  output  4  BCD code of the active digit, drives the 7-segment decoder input.
REQ-008 SHALL have port dig_sel  output  8  digit select, one-hot active-low, bit i lights position i.
REQ-009 SHALL have port dp  output  1  decimal point for the active digit, active-high.
REQ-010 SHALL have port blank  output  1  active digit suppressed; downstream forces segments off when high.

Function
REQ-011 SHALL hold a prescaler counting 0..SCAN_DIV-1; terminal count = prescaler at SCAN_DIV-1 while scan_en high.
REQ-012 SHALL, on terminal count, reset the prescaler to 0 and advance a 3-bit digit index 0->1->...->7->0.
REQ-013 SHALL, with SCAN_DIV=1, advance the index on every enabled cycle.
REQ-014 SHALL map index 0..3 to fare d0..d3 and index 4..7 to distance d0..d3.
REQ-015 SHALL hold shadow copies of fare_bcd and dist_bcd; outputs use only shadow values.
REQ-016 SHALL capture both inputs into the shadows on the terminal-count edge where the index wraps 7->0; no other capture.
REQ-017 SHALL keep the input changes mid-frame invisible until the next wrap (no tearing within a frame).
REQ-018 SHALL drive digit_bcd = shadow digit at the current index and dig_sel bit[index]=0, others 1, all settled in the cycle after the advancing edge.
REQ-019 SHALL assert dp only at index 1 and index 5 (formats ddd.d).
REQ-020 SHALL blank leading zeros per group: d3 blanked when d3=0; d2 blanked when d3=0 and d2=0; d1 and d0 never blanked.
REQ-021 SHALL, for a blanked digit, assert blank, keep dig_sel active and drive digit_bcd = 4'd0.
REQ-022 SHALL forward digit values 10..15 unchanged and never blank them.
REQ-023 SHALL, while scan_en low, freeze prescaler, index and shadows, and drive dig_sel = 8'hFF, blank = 1, dp = 0.
REQ-024 SHALL, on scan_en rising, resume from the frozen prescaler and index values without skipping or repeating a digit.

Reset
REQ-025 SHALL, while rst_n low, clear prescaler, index and both shadows to 0 immediately, regardless of clk.
REQ-026 SHALL reset outputs to digit_bcd=0, dig_sel=8'hFE, dp=0, blank=0.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame; first capture after release occurs at the first 7->0 wrap.

Verification
REQ-028 SHALL cover: SCAN_DIV=4, scan_en=1, fare=16'h1234, dist=16'h0056 after one frame -> sequence digit_bcd 4,3,2,1,6,5,0,0 each for 4 cycles; dp at positions 1,5; blank at positions 6,7.
REQ-029 SHALL cover: fare changes 16'h1234->16'h9999 while index=2 -> digits 2,3 still show 2,1; 9s appear only after the 7->0 wrap.
REQ-030 SHALL cover: fare=16'h0000 -> positions 3,2 blank=1; positions 1,0 show 0 with dp at position 1.
REQ-031 SHALL cover: scan_en dropped at index 3, prescaler 2 for 10 cycles -> dig_sel=8'hFF, blank=1; on resume index 3 lights for the remaining 2 cycles.
REQ-032 SHALL cover: rst_n pulsed low asynchronously between edges at index 6 -> outputs immediately dig_sel=8'hFE, digit_bcd=0, blank=0, dp=0.
REQ-033 SHALL cover: SCAN_DIV=1, dist=16'h00A0 -> index advances every cycle; digit value 10 forwarded at position 5 with blank=0.
